// File: rtl/ah_rr_mux.sv
// Round-robin NUM_ING-to-1 valid/ready merge with a registered egress beat tagged by source index.
// Optional packet locking (ing_last/egr_last ports) is enabled by defining AH_RR_MUX_PKT_LOCK_EN.
module ah_rr_mux #(
    parameter  int NUM_ING = 18,
    parameter  int DATA_W  = 9,
    localparam int SEL_W   = $clog2(NUM_ING)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_ING*DATA_W-1:0] ing_data,
    input  logic [NUM_ING-1:0]        ing_valid,
    output logic [NUM_ING-1:0]        ing_ready,
    output logic [DATA_W-1:0]         egr_data,
    output logic                      egr_valid,
    input  logic                      egr_ready,
    output logic [SEL_W-1:0]          egr_src
`ifdef AH_RR_MUX_PKT_LOCK_EN
    ,
    input  logic [NUM_ING-1:0]        ing_last,
    output logic                      egr_last
`endif
);

    localparam logic [SEL_W:0] NUM_ING_W = (SEL_W+1)'(NUM_ING);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_ING - 1);

    logic [DATA_W-1:0] ing_beat [NUM_ING];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ING; gi++) begin : g_unpack
            assign ing_beat[gi] = ing_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [DATA_W-1:0]  egr_data_q,  egr_data_d;
    logic               egr_valid_q, egr_valid_d;
    logic [SEL_W-1:0]   egr_src_q,   egr_src_d;
    logic [SEL_W-1:0]   ptr_q,       ptr_d;

    logic [NUM_ING-1:0] elig_valid;
    logic               load;
    logic               any_valid;
    logic               xfer;
    logic [SEL_W-1:0]   grant_idx;
    logic               grant_found;
    logic [SEL_W:0]     cand;
    logic [SEL_W-1:0]   ptr_adv;

`ifdef AH_RR_MUX_PKT_LOCK_EN
    logic               lock_q,     lock_d;
    logic [SEL_W-1:0]   lock_idx_q, lock_idx_d;
    logic               egr_last_q, egr_last_d;

    // A locked packet masks every other requester, even while its owner is idle.
    always_comb begin
        elig_valid = ing_valid;
        if (lock_q) begin
            elig_valid = ing_valid & (NUM_ING'(1) << lock_idx_q);
        end
    end
`else
    assign elig_valid = ing_valid;
`endif

    assign load      = ~egr_valid_q | egr_ready;
    assign any_valid = |elig_valid;
    assign xfer      = load & any_valid;

    // Scan from ptr upward; the extra bit in cand keeps the wrap exact for non-power-of-two counts.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_ING; k++) begin
            cand = {1'b0, ptr_q} + (SEL_W+1)'(k);
            if (cand >= NUM_ING_W) begin
                cand = cand - NUM_ING_W;
            end
            if (!grant_found && elig_valid[cand[SEL_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SEL_W-1:0];
            end
        end
    end

    assign ptr_adv = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_W'(1);

    always_comb begin
        ing_ready = '0;
        if (xfer && !rst) begin
            ing_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        egr_valid_d = egr_valid_q;
        egr_data_d  = egr_data_q;
        egr_src_d   = egr_src_q;
        ptr_d       = ptr_q;
`ifdef AH_RR_MUX_PKT_LOCK_EN
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
        egr_last_d  = egr_last_q;
`endif
        if (load) begin
            egr_valid_d = any_valid;
        end
        if (xfer) begin
            egr_data_d = ing_beat[grant_idx];
            egr_src_d  = grant_idx;
`ifdef AH_RR_MUX_PKT_LOCK_EN
            egr_last_d = ing_last[grant_idx];
            if (ing_last[grant_idx]) begin
                lock_d = 1'b0;
                ptr_d  = ptr_adv;
            end else begin
                lock_d     = 1'b1;
                lock_idx_d = grant_idx;
            end
`else
            ptr_d = ptr_adv;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            egr_valid_q <= 1'b0;
            egr_data_q  <= '0;
            egr_src_q   <= '0;
            ptr_q       <= '0;
`ifdef AH_RR_MUX_PKT_LOCK_EN
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            egr_last_q  <= 1'b0;
`endif
        end else begin
            egr_valid_q <= egr_valid_d;
            egr_data_q  <= egr_data_d;
            egr_src_q   <= egr_src_d;
            ptr_q       <= ptr_d;
`ifdef AH_RR_MUX_PKT_LOCK_EN
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            egr_last_q  <= egr_last_d;
`endif
        end
    end

    assign egr_valid = egr_valid_q;
    assign egr_data  = egr_data_q;
    assign egr_src   = egr_src_q;
`ifdef AH_RR_MUX_PKT_LOCK_EN
    assign egr_last  = egr_last_q;
`endif

endmodule
